// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lamp_pkg
// Description : Owner/mode encoding and default blink timing for lamp_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lamp_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd0,
        MODE_TURN_L = 3'd1,
        MODE_TURN_R = 3'd2,
        MODE_LANE_L = 3'd3,
        MODE_LANE_R = 3'd4,
        MODE_HAZARD = 3'd5,
        MODE_ESS    = 3'd6
    } mode_t;

    // Defaults assume a 50 MHz board clock.
    localparam int c_PERIOD_CYC     = 25_000_000;
    localparam int c_ON_CYC         = 12_500_000;
    localparam int c_ESS_PERIOD_CYC = 12_500_000;
    localparam int c_ESS_SEC        = 3;
    localparam int c_LANE_FLASHES   = 3;

    function automatic logic is_lane(input mode_t m);
        return (m == MODE_LANE_L) || (m == MODE_LANE_R);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : blink_phase_gen
// Description : Shared blink phase counter with synchronous clear and a
//               normal/fast period select; reports ON phase and last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_phase_gen #(
    parameter int PERIOD_CYC     = 25_000_000,
    parameter int ON_CYC         = 12_500_000,
    parameter int ESS_PERIOD_CYC = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_fast,
    output logic o_blink,
    output logic o_last_cycle
);

    localparam int c_MAX   = (PERIOD_CYC > ESS_PERIOD_CYC) ? PERIOD_CYC : ESS_PERIOD_CYC;
    localparam int c_CNT_W = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_N = c_CNT_W'(PERIOD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_F = c_CNT_W'(ESS_PERIOD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    // Thresholds carry one extra bit so an ON time equal to the period still fits.
    localparam logic [c_CNT_W:0]   c_ON_N   = (c_CNT_W + 1)'(ON_CYC);
    localparam logic [c_CNT_W:0]   c_ON_F   = (c_CNT_W + 1)'(ESS_PERIOD_CYC / 2);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last       = i_fast ? (r_cnt == c_LAST_F) : (r_cnt == c_LAST_N);
    assign o_last_cycle = w_last;
    assign o_blink      = i_fast ? ({1'b0, r_cnt} < c_ON_F) : ({1'b0, r_cnt} < c_ON_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lamp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lamp_arbiter
// Description : Fixed-priority owner select (ESS > HAZARD > TURN > LANE > IDLE)
//               for the indicator lamps with a single shared blink generator.
//               Lane-change support is built only with LAMP_LANE_CHANGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lamp_arbiter
    import lamp_pkg::*;
#(
    parameter int PERIOD_CYC     = c_PERIOD_CYC,
    parameter int ON_CYC         = c_ON_CYC,
    parameter int ESS_PERIOD_CYC = c_ESS_PERIOD_CYC,
    parameter int ESS_SEC        = c_ESS_SEC,
    parameter int LANE_FLASHES   = c_LANE_FLASHES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1sec,
    input  logic       sw_hazard,
    input  logic       ess_trigger,
    input  logic       is_accel_pressed,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       lane_tap_l,
    input  logic       lane_tap_r,
    output logic       lamp_left,
    output logic       lamp_right,
    output logic       ess_active_out,
    output logic [2:0] mode
);

    localparam int c_ESS_W = (ESS_SEC > 0) ? $clog2(ESS_SEC + 1) : 1;
    localparam logic [c_ESS_W-1:0] c_ESS_LOAD = c_ESS_W'(ESS_SEC);
    localparam logic [c_ESS_W-1:0] c_ESS_ONE  = c_ESS_W'(1);

    mode_t              r_mode;
    mode_t              w_mode_next;
    logic               r_ess_active;
    logic               w_ess_active_next;
    logic [c_ESS_W-1:0] r_ess_timer;
    logic [c_ESS_W-1:0] w_ess_timer_next;
    logic               w_lever_l;
    logic               w_lever_r;
    logic               w_blink;
    logic               w_last_cycle;
    logic               w_phase_clear;

    assign w_lever_l = turn_left & ~turn_right;
    assign w_lever_r = turn_right & ~turn_left;

    // A trigger overrides a simultaneous accelerator cancel.
    always_comb begin
        w_ess_active_next = r_ess_active;
        w_ess_timer_next  = r_ess_timer;
        if (ess_trigger) begin
            w_ess_active_next = 1'b1;
            w_ess_timer_next  = c_ESS_LOAD;
        end else if (r_ess_active) begin
            if (is_accel_pressed) begin
                w_ess_active_next = 1'b0;
                w_ess_timer_next  = '0;
            end else if (r_ess_timer == '0) begin
                w_ess_active_next = 1'b0;
            end else if (tick_1sec) begin
                w_ess_timer_next = r_ess_timer - c_ESS_ONE;
            end
        end
    end

`ifdef LAMP_LANE_CHANGE_EN
    localparam int c_LANE_W = (LANE_FLASHES > 0) ? $clog2(LANE_FLASHES + 1) : 1;
    localparam logic [c_LANE_W-1:0] c_LANE_LOAD = c_LANE_W'(LANE_FLASHES);
    localparam logic [c_LANE_W-1:0] c_LANE_ONE  = c_LANE_W'(1);

    logic [c_LANE_W-1:0] r_lane_cnt;
    logic [c_LANE_W-1:0] w_lane_cnt_next;
    logic                r_lane_dir;
    logic                w_lane_dir_next;
    logic                w_higher;
    logic                w_tap_ok;

    assign w_higher = w_ess_active_next | sw_hazard | w_lever_l | w_lever_r;
    assign w_tap_ok = (r_mode == MODE_IDLE) || is_lane(r_mode);

    // Lane state is dropped outright on preemption so it never resumes.
    always_comb begin
        w_lane_cnt_next = r_lane_cnt;
        w_lane_dir_next = r_lane_dir;
        if (w_higher) begin
            w_lane_cnt_next = '0;
        end else if (w_tap_ok && lane_tap_l) begin
            w_lane_dir_next = 1'b0;
            w_lane_cnt_next = c_LANE_LOAD;
        end else if (w_tap_ok && lane_tap_r) begin
            w_lane_dir_next = 1'b1;
            w_lane_cnt_next = c_LANE_LOAD;
        end else if (is_lane(r_mode) && w_last_cycle && (r_lane_cnt != '0)) begin
            w_lane_cnt_next = r_lane_cnt - c_LANE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_lane_dir <= 1'b0;
        end else begin
            r_lane_cnt <= w_lane_cnt_next;
            r_lane_dir <= w_lane_dir_next;
        end
    end
`else
    logic w_unused_lane;
    assign w_unused_lane = lane_tap_l | lane_tap_r | w_last_cycle;
`endif

    always_comb begin
        w_mode_next = MODE_IDLE;
        if (w_ess_active_next) begin
            w_mode_next = MODE_ESS;
        end else if (sw_hazard) begin
            w_mode_next = MODE_HAZARD;
        end else if (w_lever_l) begin
            w_mode_next = MODE_TURN_L;
        end else if (w_lever_r) begin
            w_mode_next = MODE_TURN_R;
        end
`ifdef LAMP_LANE_CHANGE_EN
        else if (w_lane_cnt_next != '0) begin
            w_mode_next = w_lane_dir_next ? MODE_LANE_R : MODE_LANE_L;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= MODE_IDLE;
            r_ess_active <= 1'b0;
            r_ess_timer  <= '0;
        end else begin
            r_mode       <= w_mode_next;
            r_ess_active <= w_ess_active_next;
            r_ess_timer  <= w_ess_timer_next;
        end
    end

    // Restart on owner change so the new owner begins with a full ON phase.
    assign w_phase_clear = (w_mode_next != r_mode) || (w_mode_next == MODE_IDLE);

    blink_phase_gen #(
        .PERIOD_CYC     (PERIOD_CYC),
        .ON_CYC         (ON_CYC),
        .ESS_PERIOD_CYC (ESS_PERIOD_CYC)
    ) u_phase (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_phase_clear),
        .i_fast       (r_mode == MODE_ESS),
        .o_blink      (w_blink),
        .o_last_cycle (w_last_cycle)
    );

    always_comb begin
        lamp_left  = 1'b0;
        lamp_right = 1'b0;
        case (r_mode)
            MODE_TURN_L, MODE_LANE_L: lamp_left = w_blink;
            MODE_TURN_R, MODE_LANE_R: lamp_right = w_blink;
            MODE_HAZARD, MODE_ESS: begin
                lamp_left  = w_blink;
                lamp_right = w_blink;
            end
            default: begin
                lamp_left  = 1'b0;
                lamp_right = 1'b0;
            end
        endcase
    end

    assign ess_active_out = r_ess_active;
    assign mode           = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_lamp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lamp_arbiter
// Description : Directed plus randomized checks of lamp_arbiter against an
//               owner-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lamp_arbiter;

    localparam int P     = 10;
    localparam int ON    = 5;
    localparam int EP    = 4;
    localparam int ESEC  = 3;
    localparam int LANES = 3;

    logic       clk = 1'b0;
    logic       rst, tick_1sec, sw_hazard, ess_trigger, is_accel_pressed;
    logic       turn_left, turn_right, lane_tap_l, lane_tap_r;
    logic       lamp_left, lamp_right, ess_active_out;
    logic [2:0] mode;

    int n_vec = 0;
    int n_mis = 0;

    // Model state: owner, cycles since owner took over, ESS and lane bookkeeping.
    int m_mode, m_age, m_ess_on, m_secs, m_lane, m_dir;
    bit m_lane_en;

    always #5 clk = ~clk;

    lamp_arbiter #(
        .PERIOD_CYC(P), .ON_CYC(ON), .ESS_PERIOD_CYC(EP),
        .ESS_SEC(ESEC), .LANE_FLASHES(LANES)
    ) dut (
        .clk(clk), .rst(rst), .tick_1sec(tick_1sec), .sw_hazard(sw_hazard),
        .ess_trigger(ess_trigger), .is_accel_pressed(is_accel_pressed),
        .turn_left(turn_left), .turn_right(turn_right),
        .lane_tap_l(lane_tap_l), .lane_tap_r(lane_tap_r),
        .lamp_left(lamp_left), .lamp_right(lamp_right),
        .ess_active_out(ess_active_out), .mode(mode)
    );

    task automatic model_step();
        int  n_ess, n_secs, n_lane, n_dir, n_mode;
        bit  lever, higher, in_lane;
        if (rst) begin
            m_mode = 0; m_age = 0; m_ess_on = 0; m_secs = 0; m_lane = 0; m_dir = 0;
            return;
        end
        n_ess = m_ess_on; n_secs = m_secs;
        if (ess_trigger) begin
            n_ess = 1; n_secs = ESEC;
        end else if (m_ess_on != 0) begin
            if (is_accel_pressed) begin n_ess = 0; n_secs = 0; end
            else if (m_secs == 0) n_ess = 0;
            else if (tick_1sec)   n_secs = m_secs - 1;
        end
        lever   = (turn_left != turn_right);
        higher  = (n_ess != 0) || sw_hazard || lever;
        in_lane = (m_mode == 3) || (m_mode == 4);
        n_lane = m_lane; n_dir = m_dir;
        if (higher) n_lane = 0;
        else if (m_lane_en && (m_mode == 0 || in_lane) && lane_tap_l) begin n_dir = 0; n_lane = LANES; end
        else if (m_lane_en && (m_mode == 0 || in_lane) && lane_tap_r) begin n_dir = 1; n_lane = LANES; end
        else if (in_lane && (m_age % P) == P - 1 && m_lane > 0) n_lane = m_lane - 1;
        if (n_ess != 0)              n_mode = 6;
        else if (sw_hazard)          n_mode = 5;
        else if (lever && turn_left) n_mode = 1;
        else if (lever)              n_mode = 2;
        else if (n_lane > 0)         n_mode = (n_dir != 0) ? 4 : 3;
        else                         n_mode = 0;
        m_age = (n_mode != m_mode || n_mode == 0) ? 0 : m_age + 1;
        m_mode = n_mode; m_ess_on = n_ess; m_secs = n_secs; m_lane = n_lane; m_dir = n_dir;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit blink, el, er;
        @(posedge clk);
        model_step();
        #1;
        blink = (m_mode == 6) ? ((m_age % EP) < EP / 2) : ((m_age % P) < ON);
        el = blink && (m_mode == 1 || m_mode == 3 || m_mode == 5 || m_mode == 6);
        er = blink && (m_mode == 2 || m_mode == 4 || m_mode == 5 || m_mode == 6);
        check("mode",       {1'b0, mode},            4'(m_mode));
        check("lamp_left",  {3'b0, lamp_left},       {3'b0, el});
        check("lamp_right", {3'b0, lamp_right},      {3'b0, er});
        check("ess_active", {3'b0, ess_active_out},  4'(m_ess_on));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (4) step();
            tick_1sec = 1'b1; step(); tick_1sec = 1'b0;
        end
    endtask

    initial begin
`ifdef LAMP_LANE_CHANGE_EN
        m_lane_en = 1'b1;
`else
        m_lane_en = 1'b0;
`endif
        m_mode = 0; m_age = 0; m_ess_on = 0; m_secs = 0; m_lane = 0; m_dir = 0;
        rst = 1'b1; tick_1sec = 1'b0; sw_hazard = 1'b0; ess_trigger = 1'b0;
        is_accel_pressed = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
        lane_tap_l = 1'b0; lane_tap_r = 1'b0;
        repeat (2) step();
        check("reset_mode", {1'b0, mode}, 4'd0);
        rst = 1'b0;

        // Turn lever: 5 on / 5 off on the left lamp.
        turn_left = 1'b1; repeat (25) step(); turn_left = 1'b0; repeat (3) step();

        // Lane tap right, then a re-tap 12 cycles in.
        lane_tap_r = 1'b1; step(); lane_tap_r = 1'b0; repeat (35) step();
        lane_tap_r = 1'b1; step(); lane_tap_r = 1'b0; repeat (11) step();
        lane_tap_r = 1'b1; step(); lane_tap_r = 1'b0; repeat (40) step();

        // Opposite-direction retap, then hazard preempts lane.
        lane_tap_l = 1'b1; step(); lane_tap_l = 1'b0; repeat (7) step();
        lane_tap_r = 1'b1; step(); lane_tap_r = 1'b0; repeat (4) step();
        sw_hazard = 1'b1; repeat (15) step(); sw_hazard = 1'b0; repeat (5) step();
        check("lane_not_resumed", {1'b0, mode}, 4'd0);

        // ESS on top of hazard, expiring after three ticks.
        sw_hazard = 1'b1; repeat (3) step();
        ess_trigger = 1'b1; step(); ess_trigger = 1'b0;
        ticks(3); repeat (4) step();
        check("ess_back_to_hazard", {1'b0, mode}, 4'd5);
        sw_hazard = 1'b0; repeat (3) step();

        // Accelerator cancel, then trigger and accel together.
        ess_trigger = 1'b1; step(); ess_trigger = 1'b0; repeat (4) step();
        is_accel_pressed = 1'b1; step(); is_accel_pressed = 1'b0; repeat (2) step();
        ess_trigger = 1'b1; is_accel_pressed = 1'b1; step();
        ess_trigger = 1'b0; is_accel_pressed = 1'b0;
        check("trigger_beats_accel", {3'b0, ess_active_out}, 4'd1);
        repeat (3) step();
        is_accel_pressed = 1'b1; step(); is_accel_pressed = 1'b0;

        // Both levers count as none.
        turn_left = 1'b1; turn_right = 1'b1; repeat (5) step();
        check("both_levers_idle", {1'b0, mode}, 4'd0);
        turn_left = 1'b0; turn_right = 1'b0;

        // Reset mid-ON.
        turn_right = 1'b1; repeat (3) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_lamp_right", {3'b0, lamp_right}, 4'd0);
        repeat (3) step(); turn_right = 1'b0; step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick_1sec        = ($urandom_range(0, 5) == 0);
            ess_trigger      = ($urandom_range(0, 199) == 0);
            is_accel_pressed = ($urandom_range(0, 59) == 0);
            lane_tap_l       = ($urandom_range(0, 24) == 0);
            lane_tap_r       = !lane_tap_l && ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) sw_hazard  = ~sw_hazard;
            if ($urandom_range(0, 59) == 0) turn_left  = ~turn_left;
            if ($urandom_range(0, 59) == 0) turn_right = ~turn_right;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
